// File: rtl/prt_vtb_vmon_pkg.sv
// Shared state type, default widths and lock-counter sizing for the video stream monitor.
package prt_vtb_vmon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_MEAS = 2'd2
  } vmon_state_e;

  localparam int unsigned DEF_PPC         = 2;
  localparam int unsigned DEF_PIX_W       = 16;
  localparam int unsigned DEF_LIN_W       = 16;
  localparam int unsigned DEF_FRM_W       = 16;
  localparam int unsigned DEF_LOCK_FRAMES = 3;
  localparam int unsigned DEF_TIMEOUT     = 1 << 24;

  function automatic int unsigned lock_cnt_w(input int unsigned frames);
    return $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/prt_vtb_vmon_lock.sv
// Lock tracker: remembers the previous frame's geometry and counts consecutive clean repeats.
module prt_vtb_vmon_lock
  import prt_vtb_vmon_pkg::*;
#(
  parameter int unsigned P_PIX_W       = DEF_PIX_W,
  parameter int unsigned P_LIN_W       = DEF_LIN_W,
  parameter int unsigned P_LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               clr,
  input  logic               sof_stb,
  input  logic [P_PIX_W-1:0] frm_len,
  input  logic [P_LIN_W-1:0] lin_cnt,
  input  logic               mism,
  output logic               lock
);

  localparam int unsigned     SC_W   = lock_cnt_w(P_LOCK_FRAMES);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(P_LOCK_FRAMES);

  logic [P_PIX_W-1:0] prev_len;
  logic [P_LIN_W-1:0] prev_lin;
  logic               prev_vld;
  logic [SC_W-1:0]    stable_cnt;
  logic               match;

  // The very first evaluated frame has no reference, so prev_vld gates the match.
  assign match = prev_vld && !mism && (frm_len == prev_len) && (lin_cnt == prev_lin);

  always_ff @(posedge clk_sys) begin
    if (rst || clr) begin
      prev_len   <= '0;
      prev_lin   <= '0;
      prev_vld   <= 1'b0;
      stable_cnt <= '0;
    end else if (sof_stb) begin
      prev_len <= frm_len;
      prev_lin <= lin_cnt;
      prev_vld <= 1'b1;
      if (!match)
        stable_cnt <= '0;
      else if (stable_cnt != SC_MAX)
        stable_cnt <= stable_cnt + SC_W'(1);
    end
  end

  assign lock = (stable_cnt == SC_MAX);

endmodule

// File: rtl/prt_vtb_vmon.sv
// Video stream monitor: pixels/line, lines/frame, frame count, lock and sticky error.
// Optional SOF watchdog enabled by defining PRT_VTB_VMON_TIMEOUT_EN.
module prt_vtb_vmon
  import prt_vtb_vmon_pkg::*;
#(
  parameter int unsigned P_PPC         = DEF_PPC,
  parameter int unsigned P_PIX_W       = DEF_PIX_W,
  parameter int unsigned P_LIN_W       = DEF_LIN_W,
  parameter int unsigned P_FRM_W       = DEF_FRM_W,
  parameter int unsigned P_LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int unsigned P_TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic               CTL_RUN_IN,
  input  logic               CTL_CLR_IN,
  input  logic               VID_SOF_IN,
  input  logic               VID_EOL_IN,
  input  logic               VID_VLD_IN,
  output logic [P_PIX_W-1:0] STA_PIX_OUT,
  output logic [P_LIN_W-1:0] STA_LIN_OUT,
  output logic [P_FRM_W-1:0] STA_FRM_OUT,
  output logic               STA_LOCK_OUT,
  output logic               STA_ERR_OUT
);

  // state | meaning
  // IDLE  | not running; counters and lock cleared, status words held
  // SEEK  | running, discarding beats until the first SOF beat
  // MEAS  | measuring lines and frames

  vmon_state_e state, state_nxt;

  logic               sof_beat, do_beat, do_eval, cnt_clr, wdg_fire, wdg_due, lock_clr;
  logic [P_PIX_W-1:0] pix_cnt, ref_len, pix_base, pix_new;
  logic [P_PIX_W:0]   pix_sum;
  logic [P_LIN_W-1:0] lin_cnt, lin_base, lin_new;
  logic [P_LIN_W:0]   lin_sum;
  logic               ref_vld, mism, ref_vld_base, mism_base;
  logic               pix_sat, lin_sat, len_bad, beat_err;

  assign sof_beat = VID_VLD_IN && VID_SOF_IN;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_beat   = 1'b0;
    do_eval   = 1'b0;
    cnt_clr   = 1'b0;
    wdg_fire  = 1'b0;
    if (CTL_CLR_IN) begin
      state_nxt = CTL_RUN_IN ? ST_SEEK : ST_IDLE;
    end else if (!CTL_RUN_IN || state == ST_IDLE) begin
      cnt_clr   = 1'b1;
      state_nxt = CTL_RUN_IN ? ST_SEEK : ST_IDLE;
    end else begin
      case (state)
        ST_SEEK: begin
          if (sof_beat) begin
            state_nxt = ST_MEAS;
            do_beat   = 1'b1;
          end
        end
        ST_MEAS: begin
          if (wdg_due && !sof_beat) begin
            wdg_fire  = 1'b1;
            state_nxt = ST_SEEK;
          end else if (VID_VLD_IN) begin
            do_beat = 1'b1;
            do_eval = VID_SOF_IN;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // An SOF beat opens a new frame and a new first line before its own pixels are added.
  assign pix_base     = VID_SOF_IN ? '0 : pix_cnt;
  assign lin_base     = VID_SOF_IN ? '0 : lin_cnt;
  assign ref_vld_base = VID_SOF_IN ? 1'b0 : ref_vld;
  assign mism_base    = VID_SOF_IN ? 1'b0 : mism;

  assign pix_sum  = {1'b0, pix_base} + (P_PIX_W+1)'(P_PPC);
  assign pix_sat  = pix_sum[P_PIX_W];
  assign pix_new  = pix_sat ? '1 : pix_sum[P_PIX_W-1:0];
  assign lin_sum  = {1'b0, lin_base} + (P_LIN_W+1)'(1);
  assign lin_sat  = lin_sum[P_LIN_W];
  assign lin_new  = lin_sat ? '1 : lin_sum[P_LIN_W-1:0];
  assign len_bad  = ref_vld_base && (pix_new != ref_len);
  assign beat_err = pix_sat || (VID_EOL_IN && (len_bad || lin_sat));

  always_ff @(posedge CLK_IN) begin
    if (RST_IN || CTL_CLR_IN) begin
      STA_PIX_OUT <= '0;
      STA_LIN_OUT <= '0;
      STA_FRM_OUT <= '0;
      STA_ERR_OUT <= 1'b0;
      pix_cnt     <= '0;
      lin_cnt     <= '0;
      ref_len     <= '0;
      ref_vld     <= 1'b0;
      mism        <= 1'b0;
    end else if (cnt_clr || wdg_fire) begin
      pix_cnt <= '0;
      lin_cnt <= '0;
      ref_len <= '0;
      ref_vld <= 1'b0;
      mism    <= 1'b0;
      if (wdg_fire) begin
        STA_PIX_OUT <= '0;
        STA_LIN_OUT <= '0;
        STA_ERR_OUT <= 1'b1;
      end
    end else if (do_beat) begin
      if (do_eval) begin
        STA_LIN_OUT <= lin_cnt;
        STA_FRM_OUT <= STA_FRM_OUT + P_FRM_W'(1);
      end
      mism <= mism_base || beat_err;
      if (beat_err) STA_ERR_OUT <= 1'b1;
      if (VID_EOL_IN) begin
        STA_PIX_OUT <= pix_new;
        pix_cnt     <= '0;
        lin_cnt     <= lin_new;
        ref_vld     <= 1'b1;
        if (!ref_vld_base) ref_len <= pix_new;
      end else begin
        pix_cnt <= pix_new;
        lin_cnt <= lin_base;
        ref_vld <= ref_vld_base;
      end
    end
  end

`ifdef PRT_VTB_VMON_TIMEOUT_EN
  localparam int unsigned WDG_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  logic [WDG_W-1:0] wdg_cnt;

  // Down-counter reloaded on every SOF beat and whenever measurement is not continuing.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || state_nxt != ST_MEAS || (do_beat && VID_SOF_IN))
      wdg_cnt <= WDG_W'(P_TIMEOUT - 1);
    else if (wdg_cnt != '0)
      wdg_cnt <= wdg_cnt - WDG_W'(1);
  end

  assign wdg_due = (wdg_cnt == '0);
`else
  assign wdg_due = 1'b0;
`endif

  assign lock_clr = CTL_CLR_IN || cnt_clr || wdg_fire;

  prt_vtb_vmon_lock #(
    .P_PIX_W       (P_PIX_W),
    .P_LIN_W       (P_LIN_W),
    .P_LOCK_FRAMES (P_LOCK_FRAMES)
  ) u_lock (
    .clk_sys (CLK_IN),
    .rst     (RST_IN),
    .clr     (lock_clr),
    .sof_stb (do_eval),
    .frm_len (ref_len),
    .lin_cnt (lin_cnt),
    .mism    (mism),
    .lock    (STA_LOCK_OUT)
  );

endmodule

// File: doc/prt_vtb_vmon.md
Name: prt_vtb_vmon

Overview:
Parametrised video stream monitor for the video toolbox, the successor of the fixed 16-bit pixel/line monitor.
- Measures pixels per line and lines per frame of an AXIS-style video stream at P_PPC pixels per beat.
- Counts completed frames and flags intra-frame line-length mismatches and counter overflow.
- Declares lock after P_LOCK_FRAMES consecutive identical frames.
- Sits in the RX link clock domain; its status words are crossed to the system domain by the toolbox top.

Parameters:
P_PPC, 2, pixels per valid beat (1, 2 or 4).
P_PIX_W, 16, pixel counter / STA_PIX_OUT width.
P_LIN_W, 16, line counter / STA_LIN_OUT width.
P_FRM_W, 16, frame counter width.
P_LOCK_FRAMES, 3, consecutive matching frames required for lock (1..15).
P_TIMEOUT, 2**24, watchdog cycles without SOF; used only with the optional feature.

Ports:
CLK_IN  in  1  clock; single clock domain.
RST_IN  in  1  reset, synchronous, active-high.
CTL_RUN_IN  in  1  enable measurement; level.
CTL_CLR_IN  in  1  single-cycle pulse: clear all status.
VID_SOF_IN  in  1  start of frame; qualified by VID_VLD_IN; marks the first beat of a frame.
VID_EOL_IN  in  1  end of line; qualified by VID_VLD_IN; marks the last beat of a line.
VID_VLD_IN  in  1  beat valid.
STA_PIX_OUT  out  P_PIX_W  pixels in the last completed line.
STA_LIN_OUT  out  P_LIN_W  lines in the last completed frame.
STA_FRM_OUT  out  P_FRM_W  completed-frame count; wraps.
STA_LOCK_OUT  out  1  stream stable.
STA_ERR_OUT  out  1  sticky: line-length mismatch or overflow seen.

Behaviour:
- Reset values: all STA_* outputs 0; state IDLE.
- Reset mid-operation clears all counters and state in the same cycle.
- States:
  - IDLE: entered when CTL_RUN_IN=0. Clears lock and counters; holds PIX/LIN/FRM/ERR. Goes to SEEK when CTL_RUN_IN=1.
  - SEEK: ignores all beats until SOF&VLD. On that beat it goes to MEAS and that beat starts frame counting. No LIN latch (previous frame is partial); FRM not incremented.
  - MEAS: counts. CTL_RUN_IN=0 -> IDLE.
- CTL_CLR_IN:
  - Clears all STA_* outputs, counters and the stable count.
  - Goes to SEEK if running, otherwise stays in IDLE.
  - Has priority over any simultaneous beat; that beat is discarded.
- Pixel counting (MEAS): each VLD beat adds P_PPC to pix_cnt.
- EOL beat:
  - STA_PIX_OUT <= pix_cnt+P_PPC, visible the cycle after the beat (1-cycle latency).
  - pix_cnt <= 0; lin_cnt increments.
- SOF beat in MEAS, ordered before any EOL processing on the same beat:
  - STA_LIN_OUT <= lin_cnt.
  - STA_FRM_OUT increments.
  - Lock evaluation runs (below).
  - lin_cnt <= 0; the SOF beat's pixels count toward the new first line.
- SOF and EOL on the same beat: SOF processing first, then EOL. The new frame has lin_cnt=1 and line length P_PPC.
- Line-length check:
  - The first EOL of a frame stores ref_len.
  - Any later line of the frame with length != ref_len sets the frame mismatch flag and STA_ERR_OUT.
- Saturation:
  - pix_cnt and lin_cnt saturate at all-ones and never wrap.
  - Saturation sets the mismatch flag and STA_ERR_OUT.
- STA_FRM_OUT wraps all-ones -> 0 without error.
- Lock evaluation at each SOF in MEAS. A frame "matches" when:
  - its (ref_len, lin_cnt) equals the previous frame's, and
  - its mismatch flag is clear.
  - Match: stable count increments, saturating at P_LOCK_FRAMES.
  - No match: stable count <= 0 and STA_LOCK_OUT <= 0.
  - STA_LOCK_OUT = 1 iff stable count == P_LOCK_FRAMES, registered the cycle after the SOF beat.
- After evaluation, (ref_len, lin_cnt) becomes the previous-frame reference and the mismatch flag clears. The first evaluated frame has no reference and never matches.
- Beats with VLD=0 are ignored regardless of SOF/EOL.

Optional Feature:
PRT_VTB_VMON_TIMEOUT_EN
- Defined: a watchdog counts cycles in MEAS and restarts on every SOF beat. Reaching P_TIMEOUT:
  - clears STA_LOCK_OUT, STA_PIX_OUT and STA_LIN_OUT;
  - sets STA_ERR_OUT;
  - returns to SEEK.
- Undefined: no watchdog logic; a stalled stream holds the last values and lock indefinitely.

Decomposition:
- Package prt_vtb_vmon_pkg holds:
  - state enum (IDLE, SEEK, MEAS);
  - default widths;
  - the lock-count width function (clog2 of P_LOCK_FRAMES+1).
- Sub-module prt_vtb_vmon_lock owns the previous-frame reference, the comparator and the stable counter. Inputs: SOF strobe, frame length, line count, mismatch. Output: lock.

Test Plan:
- P_PPC=2, run, 5 frames of 4 lines x 8 beats (EOL on 8th beat) -> STA_PIX_OUT=16 one cycle after first EOL. From 2nd SOF: STA_LIN_OUT=4, STA_FRM_OUT counts 1..4. STA_LOCK_OUT=1 one cycle after the 5th SOF (P_LOCK_FRAMES=3).
- Locked stream, then one frame whose 3rd line has 7 beats -> STA_ERR_OUT=1 after that EOL. STA_LOCK_OUT=0 one cycle after next SOF. Relock after 3 further good frames + 1.
- Stream starts mid-frame (2 lines then SOF) in SEEK -> no STA_LIN_OUT latch and FRM=0 at first SOF. First reported STA_LIN_OUT = full frame.
- Single beat with SOF=EOL=VLD=1, then SOF next frame -> STA_PIX_OUT=2, STA_LIN_OUT=1.
- CTL_CLR_IN pulse coincident with an EOL beat while locked -> all STA_* = 0 next cycle, beat ignored, state SEEK.
- P_PIX_W=4, P_PPC=4, line of 5 beats -> pixel count saturates at 15, STA_ERR_OUT=1. With PRT_VTB_VMON_TIMEOUT_EN and P_TIMEOUT=100, no SOF for 100 cycles -> lock/PIX/LIN cleared, ERR=1.
